// File: rtl/logic_gates_pkg.sv
// Shared constants for the mux-only logic gate bank.
// LOGIC0/LOGIC1 are the only literal data inputs any mux2 ever sees.
package logic_gates_pkg;
    localparam logic LOGIC0 = 1'b0;
    localparam logic LOGIC1 = 1'b1;
endpackage

// File: rtl/logic_gates_mux2.sv
// 1-bit 2:1 multiplexer, the single primitive the gate bank is built from.
module mux2 (
    input  logic sel,
    input  logic d0,
    input  logic d1,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

// File: rtl/logic_gates.sv
// Registered bank of two-input logic functions, each built from one mux2 per bit
// with operand a as the select. All results appear on flops one clock after capture.
module logic_gates
    import logic_gates_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] outputand,
    output logic [WIDTH-1:0] outputor,
    output logic [WIDTH-1:0] outputnot,
    output logic [WIDTH-1:0] outputnand,
    output logic [WIDTH-1:0] outputnor,
    output logic [WIDTH-1:0] outputxor,
    output logic [WIDTH-1:0] outputxnor,
    output logic             out_valid
);
    // Handshake: in_valid qualifies a/b on the rising edge; there is no ready,
    // so every valid cycle is accepted and out_valid follows one cycle later.

    logic [WIDTH-1:0] nb;
    logic [WIDTH-1:0] and_d;
    logic [WIDTH-1:0] or_d;
    logic [WIDTH-1:0] not_d;
    logic [WIDTH-1:0] nand_d;
    logic [WIDTH-1:0] nor_d;
    logic [WIDTH-1:0] xor_d;
    logic [WIDTH-1:0] xnor_d;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        // nb is the inverted b, itself a mux so no gate operator is needed.
        mux2 u_not_b (.sel(b[gi]), .d0(LOGIC1), .d1(LOGIC0), .y(nb[gi]));
        mux2 u_and   (.sel(a[gi]), .d0(LOGIC0), .d1(b[gi]),  .y(and_d[gi]));
        mux2 u_or    (.sel(a[gi]), .d0(b[gi]),  .d1(LOGIC1), .y(or_d[gi]));
        mux2 u_not   (.sel(a[gi]), .d0(LOGIC1), .d1(LOGIC0), .y(not_d[gi]));
        mux2 u_nand  (.sel(a[gi]), .d0(LOGIC1), .d1(nb[gi]), .y(nand_d[gi]));
        mux2 u_nor   (.sel(a[gi]), .d0(nb[gi]), .d1(LOGIC0), .y(nor_d[gi]));
        mux2 u_xor   (.sel(a[gi]), .d0(b[gi]),  .d1(nb[gi]), .y(xor_d[gi]));
        mux2 u_xnor  (.sel(a[gi]), .d0(nb[gi]), .d1(b[gi]),  .y(xnor_d[gi]));
    end

    // Inverting outputs also reset to zero, not to their "idle" gate value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outputand  <= '0;
            outputor   <= '0;
            outputnot  <= '0;
            outputnand <= '0;
            outputnor  <= '0;
            outputxor  <= '0;
            outputxnor <= '0;
        end else if (in_valid) begin
            outputand  <= and_d;
            outputor   <= or_d;
            outputnot  <= not_d;
            outputnand <= nand_d;
            outputnor  <= nor_d;
            outputxor  <= xor_d;
            outputxnor <= xnor_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end
endmodule

// File: tb/tb_logic_gates.sv
// Bench for logic_gates: 1-bit truth table, hold, reset cases, and an 8-bit
// vector plus random back-to-back stream checked against a reference model.
module tb_logic_gates;
    typedef struct {
        logic       a;
        logic       b;
        logic [6:0] exp; // {and, or, not, nand, nor, xor, xnor}
    } vec_t;

    logic clk;
    logic rst_n;

    logic       a1, b1, valid1;
    logic       and1, or1, not1, nand1, nor1, xor1, xnor1, ovalid1;
    logic [7:0] a8, b8;
    logic       valid8;
    logic [7:0] and8, or8, not8, nand8, nor8, xor8, xnor8;
    logic       ovalid8;

    logic [6:0]  out1;
    logic [55:0] out8;
    assign out1 = {and1, or1, not1, nand1, nor1, xor1, xnor1};
    assign out8 = {and8, or8, not8, nand8, nor8, xor8, xnor8};

    int checks = 0;
    int errors = 0;
    logic [55:0] exp_q[$];
    vec_t tbl[4];

    logic_gates #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(valid1),
        .outputand(and1), .outputor(or1), .outputnot(not1), .outputnand(nand1),
        .outputnor(nor1), .outputxor(xor1), .outputxnor(xnor1), .out_valid(ovalid1)
    );

    logic_gates #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(valid8),
        .outputand(and8), .outputor(or8), .outputnot(not8), .outputnand(nand8),
        .outputnor(nor8), .outputxor(xor8), .outputxnor(xnor8), .out_valid(ovalid8)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [55:0] ref8(input logic [7:0] a, input logic [7:0] b);
        return {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
    endfunction

    task automatic drive1(input logic a, input logic b, input logic v);
        @(negedge clk);
        a1 = a;
        b1 = b;
        valid1 = v;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{a: 1'b0, b: 1'b0, exp: 7'b0011101};
        tbl[1] = '{a: 1'b0, b: 1'b1, exp: 7'b0111010};
        tbl[2] = '{a: 1'b1, b: 1'b0, exp: 7'b0101010};
        tbl[3] = '{a: 1'b1, b: 1'b1, exp: 7'b1100001};

        rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b1; valid1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; valid8 = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_pre_clk_out1", 64'(out1), 64'd0);
        check("reset_pre_clk_ovalid1", 64'(ovalid1), 64'd0);
        check("reset_pre_clk_out8", 64'(out8), 64'd0);
        after_edge();
        after_edge();
        check("reset_held_out1", 64'(out1), 64'd0);
        check("reset_held_ovalid1", 64'(ovalid1), 64'd0);
        check("reset_held_out8", 64'(out8), 64'd0);

        // release with no valid: outputs must stay zero
        @(negedge clk);
        rst_n = 1'b1;
        valid1 = 1'b0;
        valid8 = 1'b0;
        after_edge();
        check("post_reset_idle_out1", 64'(out1), 64'd0);
        check("post_reset_idle_ovalid1", 64'(ovalid1), 64'd0);

        // truth table, back-to-back
        for (int i = 0; i < 4; i++) begin
            drive1(tbl[i].a, tbl[i].b, 1'b1);
            after_edge();
            check($sformatf("truth_%0d%0d", tbl[i].a, tbl[i].b), 64'(out1), 64'(tbl[i].exp));
            check($sformatf("truth_valid_%0d", i), 64'(ovalid1), 64'd1);
        end

        // hold: last capture was 11, now drive 00 without valid
        for (int i = 0; i < 3; i++) begin
            drive1(1'b0, 1'b0, 1'b0);
            after_edge();
            check($sformatf("hold_out_%0d", i), 64'(out1), 64'(tbl[3].exp));
            check($sformatf("hold_valid_%0d", i), 64'(ovalid1), 64'd0);
        end

        // reset mid-stream, between clock edges
        drive1(1'b1, 1'b1, 1'b1);
        after_edge();
        check("pre_midreset_out", 64'(out1), 64'(tbl[3].exp));
        drive1(1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_async_out", 64'(out1), 64'd0);
        check("midreset_async_valid", 64'(ovalid1), 64'd0);
        after_edge();
        check("midreset_held_out", 64'(out1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        a1 = 1'b0; b1 = 1'b1; valid1 = 1'b1;
        after_edge();
        check("post_midreset_out", 64'(out1), 64'(tbl[1].exp));
        check("post_midreset_valid", 64'(ovalid1), 64'd1);
        drive1(1'b0, 1'b0, 1'b0);

        // 8-bit directed vector
        @(negedge clk);
        a8 = 8'hC5; b8 = 8'h3A; valid8 = 1'b1;
        after_edge();
        check("vec8_C5_3A", 64'(out8), 64'h00_FF_3A_FF_00_FF_00);
        check("vec8_valid", 64'(ovalid8), 64'd1);

        // random back-to-back stream with scoreboard
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            valid8 = 1'b1;
            exp_q.push_back(ref8(a8, b8));
            after_edge();
            if (exp_q.size() == 0) begin
                check("stream_queue_empty", 64'd1, 64'd0);
            end else begin
                check($sformatf("stream_out_%0d", i), 64'(out8), 64'(exp_q.pop_front()));
            end
            check($sformatf("stream_valid_%0d", i), 64'(ovalid8), 64'd1);
        end
        @(negedge clk);
        valid8 = 1'b0;
        after_edge();
        check("stream_end_valid", 64'(ovalid8), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
